// File: rtl/float_pkg.sv
// Shared floating-point types plus the state encoding of the fp_add sharing arbiter.
package float_pkg;

  typedef logic [31:0] float_t;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_WAIT_SUM = 2'd2,
    ARB_RESPOND  = 2'd3
  } fp_add_arb_state_t;

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping modulo NumReq.
module rr_pick #(
  parameter int NumReq = 4,
  localparam int IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] ptr_i,
  output logic               found_o,
  output logic [IdWidth-1:0] id_o
);

  logic [2*NumReq-1:0] rot;
  logic [IdWidth:0]    cand;

  // Doubling the vector turns the wrapping scan into a plain shift.
  assign rot = {req_i, req_i} >> ptr_i;

  always_comb begin
    found_o = 1'b0;
    id_o    = '0;
    cand    = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_i} + (IdWidth+1)'(i);
      if (cand >= (IdWidth+1)'(NumReq)) cand = cand - (IdWidth+1)'(NumReq);
      if (!found_o && rot[i]) begin
        found_o = 1'b1;
        id_o    = cand[IdWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one non-pipelined fp_add between NumReq requesters, round-robin, one operation in flight.
module fp_add_arbiter
  import float_pkg::*;
#(
  parameter int NumReq = 4,
  localparam int IdWidth = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  float_t [NumReq-1:0]    req_a_i,
  input  float_t [NumReq-1:0]    req_b_i,
  output logic [NumReq-1:0]      rsp_valid_o,
  input  logic [NumReq-1:0]      rsp_ready_i,
  output float_t                 rsp_data_o,
  output logic                   fpu_op_valid_o,
  input  logic                   fpu_op_ready_i,
  output float_t                 fpu_op_a_o,
  output float_t                 fpu_op_b_o,
  input  logic                   fpu_sum_valid_i,
  output logic                   fpu_sum_ready_o,
  input  float_t                 fpu_sum_data_i,
  output logic                   busy_o,
  output logic [IdWidth-1:0]     grant_id_o,
  output fp_add_arb_state_t      state_o
);

  // Every channel is valid/ready: a transfer happens on a rising clk_i where both are high;
  // the sender holds valid and payload stable until then and never waits on ready to raise valid.

  localparam logic [NumReq-1:0] OneLsb = NumReq'(1);

  fp_add_arb_state_t  state_q;
  logic [IdWidth-1:0] ptr_q;
  logic [IdWidth-1:0] id_q;
  float_t             a_q;
  float_t             b_q;
  float_t             sum_q;
  logic               win_found;
  logic [IdWidth-1:0] win_id;
  logic               grant;

  rr_pick #(.NumReq(NumReq)) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .found_o (win_found),
    .id_o    (win_id)
  );

  // Ready is gated by reset so a held request cannot be acknowledged while the block is in reset.
  assign grant       = rst_ni && (state_q == ARB_IDLE) && win_found;
  assign req_ready_o = grant ? (OneLsb << win_id) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: if (grant) begin
          a_q     <= req_a_i[win_id];
          b_q     <= req_b_i[win_id];
          id_q    <= win_id;
          state_q <= ARB_ISSUE;
        end
        ARB_ISSUE: if (fpu_op_ready_i) state_q <= ARB_WAIT_SUM;
        ARB_WAIT_SUM: if (fpu_sum_valid_i) begin
          sum_q   <= fpu_sum_data_i;
          state_q <= ARB_RESPOND;
        end
        ARB_RESPOND: if (rsp_ready_i[id_q]) begin
          ptr_q   <= (id_q == IdWidth'(NumReq-1)) ? '0 : id_q + IdWidth'(1);
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign fpu_op_valid_o  = (state_q == ARB_ISSUE);
  assign fpu_op_a_o      = a_q;
  assign fpu_op_b_o      = b_q;
  assign fpu_sum_ready_o = (state_q == ARB_WAIT_SUM);
  assign rsp_valid_o     = (state_q == ARB_RESPOND) ? (OneLsb << id_q) : '0;
  assign rsp_data_o      = (state_q == ARB_RESPOND) ? sum_q : '0;
  assign busy_o          = (state_q != ARB_IDLE);
  assign grant_id_o      = id_q;
  assign state_o         = state_q;

  a_req_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
  a_rsp_valid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rsp_valid_o));
  a_op_sum_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                       !(fpu_op_valid_o && fpu_sum_ready_o));
  a_op_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                fpu_op_valid_o && !fpu_op_ready_i |=>
                                $stable(fpu_op_a_o) && $stable(fpu_op_b_o));

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: a 4-requester unit plus a 3-requester unit for wrap-around.
module tb_fp_add_arbiter;
  import float_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  float_t [3:0]      req_a, req_b;
  float_t            rsp_data, fpu_op_a, fpu_op_b, fpu_sum_data;
  logic              fpu_op_valid, fpu_op_ready, fpu_sum_valid, fpu_sum_ready, busy;
  logic [1:0]        grant_id;
  fp_add_arb_state_t state;

  logic [2:0]        d3_req_valid, d3_req_ready, d3_rsp_valid;
  float_t [2:0]      d3_req_a, d3_req_b;
  float_t            d3_rsp_data, d3_op_a, d3_op_b;
  logic              d3_op_valid, d3_sum_ready, d3_busy;
  logic [1:0]        d3_grant_id;
  fp_add_arb_state_t d3_state;

  int checks = 0;
  int errors = 0;

  localparam float_t RR_A [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam float_t RR_S [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  localparam float_t ONE = 32'h3F800000;

  fp_add_arbiter #(.NumReq(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .fpu_op_valid_o(fpu_op_valid), .fpu_op_ready_i(fpu_op_ready),
    .fpu_op_a_o(fpu_op_a), .fpu_op_b_o(fpu_op_b),
    .fpu_sum_valid_i(fpu_sum_valid), .fpu_sum_ready_o(fpu_sum_ready), .fpu_sum_data_i(fpu_sum_data),
    .busy_o(busy), .grant_id_o(grant_id), .state_o(state)
  );

  // The 3-requester unit shares the fp_add-side inputs; only one unit is active at a time.
  fp_add_arbiter #(.NumReq(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(d3_req_valid), .req_ready_o(d3_req_ready), .req_a_i(d3_req_a), .req_b_i(d3_req_b),
    .rsp_valid_o(d3_rsp_valid), .rsp_ready_i(rsp_ready[2:0]), .rsp_data_o(d3_rsp_data),
    .fpu_op_valid_o(d3_op_valid), .fpu_op_ready_i(fpu_op_ready),
    .fpu_op_a_o(d3_op_a), .fpu_op_b_o(d3_op_b),
    .fpu_sum_valid_i(fpu_sum_valid), .fpu_sum_ready_o(d3_sum_ready), .fpu_sum_data_i(fpu_sum_data),
    .busy_o(d3_busy), .grant_id_o(d3_grant_id), .state_o(d3_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic fpu_accept();
    fpu_op_ready = 1'b1;
    @(negedge clk);
    fpu_op_ready = 1'b0;
  endtask

  task automatic fpu_return(input float_t s);
    fpu_sum_valid = 1'b1;
    fpu_sum_data  = s;
    @(negedge clk);
    fpu_sum_valid = 1'b0;
    fpu_sum_data  = '0;
  endtask

  task automatic rsp_accept(input logic [3:0] r);
    rsp_ready = r;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    checks++; if (fpu_op_valid !== 1'b0 || fpu_sum_ready !== 1'b0) begin errors++; $display("FAIL reset_fpu_hs got %b%b exp 00", fpu_op_valid, fpu_sum_ready); end
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL reset_busy_id got %b/%0d exp 0/0", busy, grant_id); end
    checks++; if (fpu_op_a !== 32'h0 || fpu_op_b !== 32'h0) begin errors++; $display("FAIL reset_operands got %h/%h exp 0/0", fpu_op_a, fpu_op_b); end
    checks++; if (state !== ARB_IDLE || d3_busy !== 1'b0) begin errors++; $display("FAIL reset_state got %0d/%b exp 0/0", state, d3_busy); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_a[2] = 32'h3F800000; req_b[2] = 32'h40000000;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (fpu_op_valid !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL single_issue got %b/%0d exp 1/2", fpu_op_valid, grant_id); end
    checks++; if (fpu_op_a !== 32'h3F800000 || fpu_op_b !== 32'h40000000) begin errors++; $display("FAIL single_operands got %h/%h exp 3f800000/40000000", fpu_op_a, fpu_op_b); end
    fpu_accept();
    #1;
    checks++; if (fpu_sum_ready !== 1'b1 || fpu_op_valid !== 1'b0) begin errors++; $display("FAIL single_wait got %b%b exp 10", fpu_sum_ready, fpu_op_valid); end
    fpu_return(32'h40400000);
    #1;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got %b exp 0100", rsp_valid); end
    checks++; if (rsp_data !== 32'h40400000) begin errors++; $display("FAIL single_rsp_data got %h exp 40400000", rsp_data); end
    rsp_accept(4'b0100);
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || rsp_data !== 32'h0) begin errors++; $display("FAIL single_done got %b/%b/%h exp 0/0000/0", busy, rsp_valid, rsp_data); end
    // pointer now 3: between requesters 0 and 3, 3 wins; dropped again before the edge
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL single_pointer got %b exp 1000", req_ready); end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int g;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i] = RR_A[i];
      req_b[i] = ONE;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = order[k];
      #1;
      checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << g)); end
      @(negedge clk);
      #1;
      checks++; if (grant_id !== 2'(g) || fpu_op_a !== RR_A[g] || fpu_op_b !== ONE) begin errors++; $display("FAIL rr_issue[%0d] got %0d/%h exp %0d/%h", k, grant_id, fpu_op_a, g, RR_A[g]); end
      fpu_accept();
      fpu_return(RR_S[g]);
      #1;
      checks++; if (rsp_valid !== 4'(1 << g) || rsp_data !== RR_S[g]) begin errors++; $display("FAIL rr_rsp[%0d] got %b/%h exp %b/%h", k, rsp_valid, rsp_data, 4'(1 << g), RR_S[g]); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_no_accept_in_respond[%0d] got %b exp 0000", k, req_ready); end
      rsp_accept(4'(1 << g));
    end
    req_valid = '0;
  endtask

  task automatic test_wrap3();
    d3_req_valid = 3'b010; d3_req_a[1] = 32'h40000000; d3_req_b[1] = ONE;
    #1;
    checks++; if (d3_req_ready !== 3'b010) begin errors++; $display("FAIL wrap_first got %b exp 010", d3_req_ready); end
    @(negedge clk);
    d3_req_valid = '0;
    fpu_accept();
    fpu_return(32'h40400000);
    #1;
    checks++; if (d3_rsp_valid !== 3'b010 || d3_rsp_data !== 32'h40400000) begin errors++; $display("FAIL wrap_first_rsp got %b/%h exp 010/40400000", d3_rsp_valid, d3_rsp_data); end
    rsp_accept(4'b0010);
    d3_req_valid = 3'b101;
    d3_req_a[0] = 32'h40800000; d3_req_b[0] = ONE;
    d3_req_a[2] = 32'h41000000; d3_req_b[2] = ONE;
    #1;
    checks++; if (d3_req_ready !== 3'b100) begin errors++; $display("FAIL wrap_ptr2 got %b exp 100", d3_req_ready); end
    @(negedge clk);
    d3_req_valid = 3'b001;
    #1;
    checks++; if (d3_grant_id !== 2'd2 || d3_op_a !== 32'h41000000) begin errors++; $display("FAIL wrap_issue2 got %0d/%h exp 2/41000000", d3_grant_id, d3_op_a); end
    fpu_accept();
    fpu_return(32'h41100000);
    #1;
    checks++; if (d3_rsp_valid !== 3'b100 || d3_rsp_data !== 32'h41100000) begin errors++; $display("FAIL wrap_rsp2 got %b/%h exp 100/41100000", d3_rsp_valid, d3_rsp_data); end
    rsp_accept(4'b0100);
    #1;
    checks++; if (d3_req_ready !== 3'b001) begin errors++; $display("FAIL wrap_ptr0 got %b exp 001", d3_req_ready); end
    @(negedge clk);
    d3_req_valid = '0;
    #1;
    checks++; if (d3_grant_id !== 2'd0 || d3_op_a !== 32'h40800000) begin errors++; $display("FAIL wrap_issue0 got %0d/%h exp 0/40800000", d3_grant_id, d3_op_a); end
    fpu_accept();
    fpu_return(32'h40A00000);
    #1;
    checks++; if (d3_rsp_valid !== 3'b001 || d3_rsp_data !== 32'h40A00000) begin errors++; $display("FAIL wrap_rsp0 got %b/%h exp 001/40a00000", d3_rsp_valid, d3_rsp_data); end
    rsp_accept(4'b0001);
  endtask

  task automatic test_backpressure();
    // pointer is 1 after the round-robin sequence
    req_valid = 4'b0010; req_a[1] = 32'h41200000; req_b[1] = 32'h40A00000;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1000; req_a[1] = 32'hDEADBEEF; req_b[1] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (fpu_op_valid !== 1'b1 || fpu_op_a !== 32'h41200000 || fpu_op_b !== 32'h40A00000) begin errors++; $display("FAIL bp_issue_hold[%0d] got %b/%h/%h exp 1/41200000/40a00000", k, fpu_op_valid, fpu_op_a, fpu_op_b); end
      checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_issue_busy[%0d] got %b/%b exp 1/0000", k, busy, req_ready); end
      @(negedge clk);
    end
    fpu_accept();
    fpu_return(32'h41700000);
    rsp_ready = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 32'h41700000) begin errors++; $display("FAIL bp_rsp_hold[%0d] got %b/%h exp 0010/41700000", k, rsp_valid, rsp_data); end
      checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_rsp_busy[%0d] got %b/%b exp 1/0000", k, busy, req_ready); end
      @(negedge clk);
    end
    rsp_accept(4'b0010);
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 4'b1000) begin errors++; $display("FAIL bp_after got %b/%b exp 0/1000", busy, req_ready); end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    // pointer is 2
    req_valid = 4'b0100; req_a[2] = 32'h40400000; req_b[2] = ONE;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ar_ready got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    fpu_accept();
    #1;
    checks++; if (fpu_sum_ready !== 1'b1) begin errors++; $display("FAIL ar_wait got %b exp 1", fpu_sum_ready); end
    req_valid = 4'b0011;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || state !== ARB_IDLE) begin errors++; $display("FAIL ar_state got %b/%0d exp 0/0", busy, state); end
    checks++; if (fpu_sum_ready !== 1'b0 || fpu_op_valid !== 1'b0 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL ar_hs got %b/%b/%b exp 0/0/0000", fpu_sum_ready, fpu_op_valid, rsp_valid); end
    checks++; if (req_ready !== 4'b0000 || grant_id !== 2'd0 || fpu_op_a !== 32'h0) begin errors++; $display("FAIL ar_regs got %b/%0d/%h exp 0000/0/0", req_ready, grant_id, fpu_op_a); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0010; req_a[1] = 32'h40C00000; req_b[1] = ONE;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ar_regrant got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (grant_id !== 2'd1 || fpu_op_a !== 32'h40C00000) begin errors++; $display("FAIL ar_issue got %0d/%h exp 1/40c00000", grant_id, fpu_op_a); end
    fpu_accept();
    fpu_return(32'h40E00000);
    #1;
    checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 32'h40E00000) begin errors++; $display("FAIL ar_rsp got %b/%h exp 0010/40e00000", rsp_valid, rsp_data); end
    rsp_accept(4'b0010);
  endtask

  task automatic test_drop();
    // pointer is 2; requester 1 is the only one asking
    req_valid = 4'b0010; req_a[1] = ONE; req_b[1] = ONE;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL drop_ready1 got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1000; req_a[3] = 32'h41000000; req_b[3] = ONE;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL drop_busy_ready got %b exp 0000", req_ready); end
    fpu_accept();
    req_valid = 4'b0000;
    fpu_return(32'h40000000);
    #1;
    checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 32'h40000000) begin errors++; $display("FAIL drop_rsp1 got %b/%h exp 0010/40000000", rsp_valid, rsp_data); end
    rsp_accept(4'b0010);
    req_valid = 4'b0001; req_a[0] = 32'h40000000; req_b[0] = ONE;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL drop_skip3 got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    fpu_accept();
    fpu_return(32'h40400000);
    #1;
    checks++; if (rsp_valid !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL drop_rsp0 got %b/%0d exp 0001/0", rsp_valid, grant_id); end
    rsp_accept(4'b0001);
    repeat (3) begin
      #1;
      checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL drop_quiet got %b/%b exp 0000/0", rsp_valid, busy); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    d3_req_valid = '0; d3_req_a = '0; d3_req_b = '0;
    fpu_op_ready = 1'b0; fpu_sum_valid = 1'b0; fpu_sum_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap3();
    test_backpressure();
    test_async_reset();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
